pio_avm_initiator: RTL and testbench
====================================

Name: pio_avm_initiator

Overview:
- Single-outstanding Avalon-MM initiator that drives PIO-style responders such as the kernel output/input PIO ports.
- Accepts one read/write command per valid/ready handshake and runs the bus strobes (chipselect, write_n, read_n), honouring waitrequest and fixed read latency.
- Returns one response pulse per command.
- Sits between a local control FSM (DDS parameter loader) and the PIO slaves, so hardware can update PIO registers without the NIOS core.

Parameters:
- ADDR_W, 2, width of the responder word address.
- DATA_W, 32, width of write and read data.
- READ_WAIT, 1, fixed read latency in cycles after read acceptance (0..15).
- TIMEOUT_CYC, 255, waitrequest cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block is IDLE and can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_W  target word address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_error  out  1  transfer aborted by timeout.
- avm_address  out  ADDR_W  bus address.
- avm_chipselect  out  1  bus select.
- avm_write_n  out  1  active-low write strobe.
- avm_read_n  out  1  active-low read strobe.
- avm_writedata  out  DATA_W  bus write data.
- avm_readdata  in  DATA_W  responder read data.
- avm_waitrequest  in  1  responder stall; tie 0 for zero-wait PIOs.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All avm_* and rsp_* outputs are registered.
- Reset values: avm_chipselect 0, avm_write_n 1, avm_read_n 1, avm_address 0, avm_writedata 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, state IDLE. cmd_ready is forced to 0 while reset is high.
- IDLE:
  - cmd_ready = 1.
  - A handshake (cmd_valid & cmd_ready) latches address, data and direction.
  - Next state is WRITE or READ; strobes assert in the first cycle of that state.
- WRITE:
  - chipselect 1, write_n 0; address and writedata held stable.
  - While waitrequest = 1, stay in WRITE.
  - On the first cycle with waitrequest = 0, the transfer completes; go to RESP with rsp_rdata 0.
- READ:
  - chipselect 1, read_n 0, held while waitrequest = 1.
  - On acceptance (waitrequest = 0):
    - READ_WAIT = 0: capture avm_readdata in that cycle and go to RESP.
    - READ_WAIT > 0: go to RWAIT.
- RWAIT:
  - Strobes deasserted; a 4-bit counter runs READ_WAIT cycles.
  - avm_readdata is captured in the READ_WAIT-th cycle after acceptance; then go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - There is no response backpressure.
- Latency, handshake to rsp_valid with no stall: write 2 cycles; read 2 + READ_WAIT cycles.
- cmd_valid held high during the busy period is ignored (cmd_ready is low). The next command is accepted in the first IDLE cycle.
- Reset mid-transfer: strobes deassert at the next edge, the command is dropped, and no rsp_valid is generated.
- Strobes never assert in IDLE, RWAIT or RESP. chipselect never asserts without exactly one of write_n/read_n low.

Optional Feature:
- Macro: PIO_AVM_TIMEOUT_EN.
- When defined:
  - A counter increments each WRITE/READ cycle with waitrequest = 1 and clears on leaving those states.
  - On reaching TIMEOUT_CYC, strobes deassert and the block goes to RESP with rsp_error = 1 and rsp_rdata = 0.
- When undefined:
  - The block waits indefinitely.
  - rsp_error is a constant 0 and the counter logic is absent.

Decomposition:
- Package pio_avm_pkg:
  - state encoding IDLE=0, WRITE=1, READ=2, RWAIT=3, RESP=4 (3-bit);
  - the RWAIT counter width constant (4);
  - the default TIMEOUT_CYC.
- One natural sub-module: pio_avm_wdog, the waitrequest timeout counter. It is instantiated only under PIO_AVM_TIMEOUT_EN.
- The FSM and datapath stay in the top level.

Test Plan:
- Write, zero-wait: cmd write addr 0 data 0x5 at cycle 0.
  - Required: chipselect = 1, write_n = 0, address 0, writedata 0x5 in cycle 1 only.
  - rsp_valid = 1 in cycle 2 with rdata 0; cmd_ready = 1 in cycle 3.
- Read, READ_WAIT = 1: cmd read addr 0 at cycle 0; responder drives readdata 0x0000000A in cycle 2.
  - Required: read_n = 0 in cycle 1 only.
  - rsp_valid in cycle 3 with rsp_rdata 0x0000000A.
- Waitrequest stall: write addr 1 data 0xF with waitrequest high in cycles 1–3.
  - Required: strobes held, address and data stable through cycle 4.
  - rsp_valid in cycle 5.
- Back-to-back: cmd_valid held high for two writes (0x1, 0x2).
  - Required: second handshake in cycle 3.
  - Exactly one write strobe per command, in order, with no overlap.
- Reset mid-read: reset asserted in cycle 1 of a read.
  - Required: strobes inactive from cycle 2 and no rsp_valid.
  - cmd_ready = 1 in the first cycle after reset deasserts.
- PIO_AVM_TIMEOUT_EN, TIMEOUT_CYC = 4: waitrequest stuck high.
  - Required: strobes drop after 4 stalled cycles; rsp_valid with rsp_error = 1 the following cycle.

Source files
------------

// File: rtl/pio_avm_pkg.sv
// Shared types and constants for the PIO Avalon-MM initiator.
// The optional waitrequest timeout is enabled with `define PIO_AVM_TIMEOUT_EN.
package pio_avm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int RWAIT_CNT_W     = 4;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/pio_avm_if.sv
// Command/response and Avalon-MM bus bundle for pio_avm_initiator.
// The timeout-related rsp_error only toggles when PIO_AVM_TIMEOUT_EN is defined.
interface pio_avm_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  // Command handshake: a transfer happens on a rising clk edge where both
  // cmd_valid and cmd_ready are high; cmd_* fields are sampled on that edge.
  // The response side has no backpressure: rsp_valid is a one-cycle pulse.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

endinterface

// File: rtl/pio_avm_wdog.sv
// Waitrequest watchdog: flags expiry on the TIMEOUT_CYC-th stalled cycle of a transfer.
// Only instantiated when PIO_AVM_TIMEOUT_EN is defined.
module pio_avm_wdog
  import pio_avm_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic stall,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  // Accumulates stalls for the whole transfer; cleared once the FSM leaves WRITE/READ.
  always_ff @(posedge clk) begin
    if (reset || !busy) begin
      count <= '0;
    end else if (stall) begin
      count <= count + 1'b1;
    end
  end

  assign expire = busy && stall && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pio_avm_initiator.sv
// Single-outstanding Avalon-MM initiator for PIO responders (registered strobes, fixed read latency).
// Define PIO_AVM_TIMEOUT_EN to abort transfers stalled by waitrequest for TIMEOUT_CYC cycles.
module pio_avm_initiator
  import pio_avm_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32,
  parameter int READ_WAIT   = 1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic      clk,
  input  logic      reset,
  pio_avm_if.master bus,
  output state_t    dbg_state
);

  localparam logic [RWAIT_CNT_W-1:0] READ_WAIT_C = RWAIT_CNT_W'(READ_WAIT);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   cs_q, cs_d;
  logic                   write_n_q, write_n_d;
  logic                   read_n_q, read_n_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [RWAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                   expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Strobes are computed one cycle ahead so they are flop outputs in the state they belong to.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    read_n_d    = 1'b1;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = bus.cmd_write ? ST_WRITE : ST_READ;
          addr_d    = bus.cmd_address;
          wdata_d   = bus.cmd_wdata;
          cs_d      = 1'b1;
          write_n_d = !bus.cmd_write;
          read_n_d  = bus.cmd_write;
        end
      end
      ST_WRITE: begin
        if (expire || !bus.avm_waitrequest) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
        end else begin
          cs_d      = 1'b1;
          write_n_d = 1'b0;
        end
      end
      ST_READ: begin
        if (expire) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
        end else if (bus.avm_waitrequest) begin
          cs_d     = 1'b1;
          read_n_d = 1'b0;
        end else if (READ_WAIT == 0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = bus.avm_readdata;
        end else begin
          // The first RWAIT cycle is already cycle 1 after acceptance.
          state_d = ST_RWAIT;
          cnt_d   = RWAIT_CNT_W'(1);
        end
      end
      ST_RWAIT: begin
        if (cnt_q == READ_WAIT_C) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = bus.avm_readdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef PIO_AVM_TIMEOUT_EN
  logic busy;
  logic rsp_error_q;

  assign busy = (state_q == ST_WRITE) || (state_q == ST_READ);

  pio_avm_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .busy   (busy),
    .stall  (bus.avm_waitrequest),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_error_q <= 1'b0;
    end else begin
      rsp_error_q <= expire;
    end
  end

  assign bus.rsp_error = rsp_error_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign expire        = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.cmd_ready      = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_read_n     = read_n_q;
  assign bus.avm_writedata  = wdata_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_pio_avm_initiator.sv
// Directed bench for pio_avm_initiator with READ_WAIT=1 and TIMEOUT_CYC=4.
// Covers the abort path when compiled with PIO_AVM_TIMEOUT_EN, the indefinite stall otherwise.
module tb_pio_avm_initiator;
  import pio_avm_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;

  pio_avm_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  pio_avm_initiator #(
    .ADDR_W      (2),
    .DATA_W      (32),
    .READ_WAIT   (1),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {chipselect, write_n, read_n}: idle 011, write 101, read 110
  function automatic logic [31:0] strobes();
    return {29'd0, bus.avm_chipselect, bus.avm_write_n, bus.avm_read_n};
  endfunction

  task automatic offer(input logic wr, input logic [1:0] addr, input logic [31:0] data);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_address = addr;
    bus.cmd_wdata   = data;
  endtask

  initial begin
    reset               = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_write       = 1'b0;
    bus.cmd_address     = 2'd0;
    bus.cmd_wdata       = 32'd0;
    bus.avm_readdata    = 32'd0;
    bus.avm_waitrequest = 1'b0;

    // Reset state
    step(); step(); #1;
    check("rst_strobes", strobes(), 32'h3);
    check("rst_address", 32'(bus.avm_address), 32'h0);
    check("rst_wdata", bus.avm_writedata, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_error", 32'(bus.rsp_error), 32'h0);
    check("rst_ready", 32'(bus.cmd_ready), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0; #1;
    check("rst_ready_release", 32'(bus.cmd_ready), 32'h1);

    // Write, zero-wait: handshake in cycle 0
    offer(1'b1, 2'd0, 32'h5); #1;
    step(); bus.cmd_valid = 1'b0; #1;
    check("w0_c1_strobes", strobes(), 32'h5);
    check("w0_c1_address", 32'(bus.avm_address), 32'h0);
    check("w0_c1_wdata", bus.avm_writedata, 32'h5);
    check("w0_c1_state", 32'(dbg_state), 32'(ST_WRITE));
    check("w0_c1_ready", 32'(bus.cmd_ready), 32'h0);
    step(); #1;
    check("w0_c2_strobes", strobes(), 32'h3);
    check("w0_c2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("w0_c2_rdata", bus.rsp_rdata, 32'h0);
    step(); #1;
    check("w0_c3_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("w0_c3_ready", 32'(bus.cmd_ready), 32'h1);

    // Read with one cycle of latency; only the cycle-2 readdata may be captured
    offer(1'b0, 2'd0, 32'h0); #1;
    step(); bus.cmd_valid = 1'b0; bus.avm_readdata = 32'hDEADBEEF; #1;
    check("r0_c1_strobes", strobes(), 32'h6);
    check("r0_c1_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    step(); bus.avm_readdata = 32'h0000000A; #1;
    check("r0_c2_strobes", strobes(), 32'h3);
    check("r0_c2_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("r0_c2_state", 32'(dbg_state), 32'(ST_RWAIT));
    step(); bus.avm_readdata = 32'h00000055; #1;
    check("r0_c3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("r0_c3_rdata", bus.rsp_rdata, 32'h0000000A);
    check("r0_c3_strobes", strobes(), 32'h3);
    step(); #1;
    check("r0_c4_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("r0_c4_ready", 32'(bus.cmd_ready), 32'h1);

    // Write stalled by waitrequest in cycles 1..3
    offer(1'b1, 2'd1, 32'hF); #1;
    for (int c = 1; c <= 4; c++) begin
      step(); bus.cmd_valid = 1'b0; bus.avm_waitrequest = (c <= 3); #1;
      check($sformatf("ws_c%0d_strobes", c), strobes(), 32'h5);
      check($sformatf("ws_c%0d_address", c), 32'(bus.avm_address), 32'h1);
      check($sformatf("ws_c%0d_wdata", c), bus.avm_writedata, 32'hF);
      check($sformatf("ws_c%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
    end
    step(); #1;
    check("ws_c5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("ws_c5_rdata", bus.rsp_rdata, 32'h0);
    check("ws_c5_strobes", strobes(), 32'h3);
    step(); #1;

    // Back-to-back writes with cmd_valid held high
    offer(1'b1, 2'd2, 32'h1); #1;
    step(); bus.cmd_wdata = 32'h2; #1;
    check("bb_c1_strobes", strobes(), 32'h5);
    check("bb_c1_wdata", bus.avm_writedata, 32'h1);
    check("bb_c1_ready", 32'(bus.cmd_ready), 32'h0);
    step(); #1;
    check("bb_c2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("bb_c2_ready", 32'(bus.cmd_ready), 32'h0);
    check("bb_c2_strobes", strobes(), 32'h3);
    step(); #1;
    check("bb_c3_ready", 32'(bus.cmd_ready), 32'h1);
    check("bb_c3_strobes", strobes(), 32'h3);
    step(); bus.cmd_valid = 1'b0; #1;
    check("bb_c4_strobes", strobes(), 32'h5);
    check("bb_c4_wdata", bus.avm_writedata, 32'h2);
    step(); #1;
    check("bb_c5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("bb_c5_strobes", strobes(), 32'h3);
    step(); #1;
    check("bb_c6_ready", 32'(bus.cmd_ready), 32'h1);

    // Reset asserted during cycle 1 of a read
    offer(1'b0, 2'd3, 32'h0); #1;
    step(); bus.cmd_valid = 1'b0; reset = 1'b1; #1;
    check("rr_c1_strobes", strobes(), 32'h6);
    check("rr_c1_ready", 32'(bus.cmd_ready), 32'h0);
    step(); reset = 1'b0; #1;
    check("rr_c2_strobes", strobes(), 32'h3);
    check("rr_c2_ready", 32'(bus.cmd_ready), 32'h1);
    check("rr_c2_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    for (int c = 3; c <= 5; c++) begin
      step(); #1;
      check($sformatf("rr_c%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
      check($sformatf("rr_c%0d_strobes", c), strobes(), 32'h3);
    end

`ifdef PIO_AVM_TIMEOUT_EN
    // Waitrequest stuck high: abort after four stalled cycles
    offer(1'b1, 2'd2, 32'h1234); #1;
    for (int c = 1; c <= 4; c++) begin
      step(); bus.cmd_valid = 1'b0; bus.avm_waitrequest = 1'b1; #1;
      check($sformatf("to_c%0d_strobes", c), strobes(), 32'h5);
      check($sformatf("to_c%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
    end
    step(); #1;
    check("to_c5_strobes", strobes(), 32'h3);
    check("to_c5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("to_c5_error", 32'(bus.rsp_error), 32'h1);
    check("to_c5_rdata", bus.rsp_rdata, 32'h0);
    bus.avm_waitrequest = 1'b0;
    step(); #1;
    check("to_c6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("to_c6_error", 32'(bus.rsp_error), 32'h0);
    check("to_c6_ready", 32'(bus.cmd_ready), 32'h1);
`else
    // Long stall without the timeout feature: no abort, completion after release
    offer(1'b1, 2'd2, 32'h1234); #1;
    for (int c = 1; c <= 7; c++) begin
      step(); bus.cmd_valid = 1'b0; bus.avm_waitrequest = (c <= 6); #1;
      check($sformatf("ls_c%0d_strobes", c), strobes(), 32'h5);
      check($sformatf("ls_c%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
    end
    step(); #1;
    check("ls_c8_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("ls_c8_error", 32'(bus.rsp_error), 32'h0);
    check("ls_c8_strobes", strobes(), 32'h3);
    step(); #1;
    check("ls_c9_ready", 32'(bus.cmd_ready), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
